// File: rtl/key_scan_pkg.sv
// Shared keypad definitions: scanner state encoding, one-hot column codes and
// small helpers used by the scanner.
package key_scan_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] COL_0 = 4'b0001;
  localparam logic [3:0] COL_1 = 4'b0010;
  localparam logic [3:0] COL_2 = 4'b0100;
  localparam logic [3:0] COL_3 = 4'b1000;

  // Any non-code value falls back to COL_0 so the drive can never leave one-hot.
  function automatic logic [3:0] next_col(input logic [3:0] c);
    case (c)
      COL_0:   next_col = COL_1;
      COL_1:   next_col = COL_2;
      COL_2:   next_col = COL_3;
      default: next_col = COL_0;
    endcase
  endfunction

  function automatic logic one_hot4(input logic [3:0] v);
    one_hot4 = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, W bits wide.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: rotates a one-hot column drive, debounces a single
// pressed key and its release, and reports the accepted row/column code.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_drv,
  output logic [3:0] fil,
  output logic [3:0] col,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

  logic [3:0]    row_s;
  state_e        state_q, state_d;
  logic [3:0]    col_drv_q, col_drv_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cap_q, cap_d;
  logic [3:0]    fil_q, fil_d;
  logic [3:0]    col_q, col_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  sync2 #(.W(4)) u_sync (
    .clk1  (clk1),
    .rst_n (rst_n),
    .d_i   (row_in),
    .q_o   (row_s)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      col_drv_q   <= COL_0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
      fil_q       <= '0;
      col_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_drv_q   <= col_drv_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      fil_q       <= fil_d;
      col_q       <= col_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_drv_d   = col_drv_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    fil_d       = fil_q;
    col_d       = col_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      ST_SCAN: begin
        // Rows are only looked at once the column has settled for a full dwell.
        if (dwell_q == DWELL_LAST) begin
          if (one_hot4(row_s)) begin
            cap_d   = row_s;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_drv_d = next_col(col_drv_q);
            dwell_d   = '0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_s == cap_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d     = ST_PRESSED;
            fil_d       = cap_q;
            col_d       = col_drv_q;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d   = ST_SCAN;
          col_drv_d = next_col(col_drv_q);
          dwell_d   = '0;
        end
      end
      ST_PRESSED: begin
        if (row_s == 4'd0) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Any bounce back to nonzero restarts the release qualification.
        if (row_s != 4'd0) begin
          cnt_d   = '0;
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          key_held_d = 1'b0;
          state_d    = ST_SCAN;
          col_drv_d  = next_col(col_drv_q);
          dwell_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  assign col_drv   = col_drv_q;
  assign fil       = fil_q;
  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with SCAN_DIV=4, DEBOUNCE_CNT=8.
module tb_key_scan;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_drv, fil, col;
  logic       key_valid, key_held;

  int n_chk  = 0;
  int n_fail = 0;
  int n_vld  = 0;

  key_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_drv   (col_drv),
    .fil       (fil),
    .col       (col),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk1 = ~clk1;

  always @(negedge clk1) if (key_valid) n_vld++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  // Returns just after the edge on which col_drv switches to tgt.
  task automatic wait_col(input logic [3:0] tgt);
    logic [3:0] prev;
    logic       hit;
    prev = col_drv;
    hit  = 1'b0;
    for (int n = 0; n < 64 && !hit; n++) begin
      tick(1);
      if (col_drv == tgt && prev != tgt) hit = 1'b1;
      prev = col_drv;
    end
    if (!hit) chk("wait_col_timeout", {28'd0, col_drv}, {28'd0, tgt});
  endtask

  initial begin
    logic held_ok;
    rst_n  = 1'b0;
    row_in = 4'd0;

    // Reset state
    tick(2);
    chk("rst_col_drv", col_drv, 4'b0001);
    chk("rst_fil", fil, 4'b0000);
    chk("rst_col", col, 4'b0000);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    rst_n = 1'b1;

    // Idle rotation, 4 cycles per column
    tick(3); chk("rot_hold0", col_drv, 4'b0001);
    tick(1); chk("rot_c1", col_drv, 4'b0010);
    tick(4); chk("rot_c2", col_drv, 4'b0100);
    tick(4); chk("rot_c3", col_drv, 4'b1000);
    tick(4); chk("rot_wrap", col_drv, 4'b0001);

    // Two rows at once is never accepted
    wait_col(4'b0010);
    row_in = 4'b0110;
    tick(4); chk("multi_c2", col_drv, 4'b0100);
    tick(4); chk("multi_c3", col_drv, 4'b1000);
    tick(4); chk("multi_c0", col_drv, 4'b0001);
    row_in = 4'd0;
    chk("multi_novalid", n_vld, 0);

    // Bounce during debounce aborts and moves to the next column
    wait_col(4'b0100);
    row_in = 4'b0100;
    tick(3); row_in = 4'b0000;
    tick(2); chk("bounce_hold", col_drv, 4'b0100);
    tick(1); chk("bounce_next", col_drv, 4'b1000);
    tick(4); chk("bounce_resume", col_drv, 4'b0001);
    chk("bounce_novalid", n_vld, 0);

    // Clean press at column 0010: sample 4 edges in, key_valid 8 edges later
    wait_col(4'b0010);
    row_in = 4'b0100;
    tick(11);
    chk("acc_early", key_valid, 1'b0);
    tick(1);
    chk("acc_valid", key_valid, 1'b1);
    chk("acc_fil", fil, 4'b0100);
    chk("acc_col", col, 4'b0010);
    chk("acc_held", key_held, 1'b1);
    chk("acc_drv", col_drv, 4'b0010);
    tick(1);
    chk("acc_pulse", key_valid, 1'b0);
    chk("acc_cnt", n_vld, 1);

    // Second key while held is ignored
    row_in = 4'b0101;
    tick(10);
    chk("second_cnt", n_vld, 1);
    chk("second_fil", fil, 4'b0100);
    chk("second_drv", col_drv, 4'b0010);
    row_in = 4'b0100;
    tick(3);

    // Release with one bounce: 5 low, 2 high, then low until released
    row_in  = 4'b0000;
    held_ok = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick(1);
      held_ok = held_ok & key_held;
      if (i == 5) row_in = 4'b0100;
      if (i == 7) row_in = 4'b0000;
    end
    chk("rel_held_run", held_ok, 1'b1);
    tick(1);
    chk("rel_dropped", key_held, 1'b0);
    chk("rel_next_col", col_drv, 4'b0100);
    chk("rel_fil", fil, 4'b0100);
    chk("rel_col", col, 4'b0010);
    chk("rel_cnt", n_vld, 1);

    // Reset at debounce count 4 discards the pending key
    wait_col(4'b1000);
    row_in = 4'b0001;
    tick(8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_drv", col_drv, 4'b0001);
    chk("mid_rst_fil", fil, 4'b0000);
    chk("mid_rst_col", col, 4'b0000);
    chk("mid_rst_valid", key_valid, 1'b0);
    chk("mid_rst_held", key_held, 1'b0);
    row_in = 4'd0;
    tick(2);
    rst_n = 1'b1;
    chk("post_rst_drv", col_drv, 4'b0001);
    tick(4); chk("post_rst_c1", col_drv, 4'b0010);
    tick(8); chk("post_rst_c3", col_drv, 4'b1000);
    chk("post_rst_cnt", n_vld, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk1 cycles each column is driven while scanning (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20000, consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-003 SHALL have port clk1  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port row_in  input  4  raw keypad row lines, active-high, asynchronous to clk1.
REQ-006 SHALL have port col_drv  output  4  one-hot column drive to the keypad matrix.
REQ-007 SHALL have port fil  output  4  one-hot row code of the last accepted key, for the downstream decoder.
REQ-008 SHALL have port col  output  4  one-hot column code of the last accepted key, for the downstream decoder.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-010 SHALL have port key_held  output  1  high while the accepted key remains pressed.

Function
REQ-011 SHALL pass row_in through a two-flop synchronizer (row_s) before any use; all row references below mean row_s.
REQ-012 SHALL implement the states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-013 In SCAN, SHALL count a dwell counter from 0 to SCAN_DIV-1 per column, sampling row_s only at dwell = SCAN_DIV-1.
REQ-014 At that sample, if row_s is exactly one-hot, SHALL capture row_s, hold col_drv, clear the debounce counter and enter DEBOUNCE.
REQ-015 At that sample, otherwise (zero bits or two or more bits set), SHALL rotate col_drv 0001->0010->0100->1000->0001 and clear dwell.
REQ-016 In DEBOUNCE, SHALL increment the counter each cycle row_s equals the captured row.
REQ-017 In DEBOUNCE, when the counter reaches DEBOUNCE_CNT-1, SHALL enter PRESSED.
REQ-018 In DEBOUNCE, on any mismatch, SHALL return to SCAN, rotate col_drv to the next column and clear dwell.
REQ-019 On the edge entering PRESSED, SHALL load fil with the captured row and col with col_drv, assert key_valid for exactly one cycle, and set key_held.
REQ-020 Accept latency SHALL be DEBOUNCE_CNT cycles from the sample cycle to key_valid, given a stable row.
REQ-021 In PRESSED, SHALL hold col_drv, and on row_s = 0000 SHALL clear the counter and enter RELEASE.
REQ-022 In RELEASE, SHALL count consecutive row_s = 0000 cycles; any nonzero row_s SHALL return to PRESSED with the counter cleared.
REQ-023 In RELEASE, on reaching DEBOUNCE_CNT-1, SHALL clear key_held, enter SCAN, rotate col_drv and clear dwell.
REQ-024 fil and col SHALL hold their values from key_valid until the next accepted key, and SHALL never change outside the REQ-019 edge.
REQ-025 SHALL never drive col_drv with other than exactly one bit set.
REQ-026 A second key pressed while in PRESSED or RELEASE SHALL be ignored, with no key_valid.

Reset
REQ-027 On rst_n low, SHALL immediately force: state SCAN, col_drv 0001, fil 0000, col 0000, key_valid 0, key_held 0, all counters and synchronizer flops 0.
REQ-028 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL discard the pending key, producing no key_valid.
REQ-029 After reset release, scanning SHALL resume at column 0001 with dwell 0.

Structure
REQ-030 The state encoding and the four one-hot column constants SHALL live in the shared keypad package.
REQ-031 The two-flop synchronizer SHALL be a separate sub-module, sync2, instantiated 4 bits wide.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-032 Reset release, no keys -> col_drv rotates 0001,0010,0100,1000,0001 every 4 cycles; key_valid stays 0.
REQ-033 row_in=0100 held stable while col_drv=0010 -> key_valid pulses once 8 cycles after the sample; fil=0100, col=0010, key_held=1.
REQ-034 row_in toggling 0100/0000 every 3 cycles during DEBOUNCE -> no key_valid; scanning resumes at the next column.
REQ-035 row_in=0110 -> no key_valid; col_drv keeps rotating.
REQ-036 After an accepted key, row_in=0000 for 5 cycles then 0100, then 0000 for 8 cycles -> key_held stays 1 until the 8-cycle run completes, then drops to 0; no second key_valid; fil and col are unchanged.
REQ-037 rst_n pulsed low at debounce count 4 -> key_valid never asserts; outputs are at reset values; col_drv restarts at 0001.
